// File: rtl/vga_sram_sched_pkg.sv
// Shared definitions for the VGA / pixel-SRAM scheduler: slot encoding and
// frame geometry of the 320x240 source doubled to 640x480.
package vga_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_CLI  = 2'd2
  } slot_e;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int SRC_W = 320;
  localparam int SRC_H = 240;

endpackage

// File: rtl/vga_sram_sched_if.sv
// Client bus between the image-filter engine (master) and the SRAM scheduler
// (slave): request held with its command until the one-cycle grant.
interface vga_sram_sched_if;

  logic        cli_req;
  logic        cli_we;
  logic [16:0] cli_addr;
  logic [15:0] cli_wdata;
  logic        cli_gnt;
  logic        cli_rvalid;
  logic [15:0] cli_rdata;

  modport master (
    output cli_req, cli_we, cli_addr, cli_wdata,
    input  cli_gnt, cli_rvalid, cli_rdata
  );

  modport slave (
    input  cli_req, cli_we, cli_addr, cli_wdata,
    output cli_gnt, cli_rvalid, cli_rdata
  );

endinterface

// File: rtl/vga_sram_sched_rgb565_expand.sv
// RGB565 to 3x10-bit colour expansion by MSB replication, so full-scale
// source values map to full-scale 10-bit outputs.
module rgb565_expand (
  input  logic [15:0] pix_i,
  output logic [9:0]  r_o,
  output logic [9:0]  g_o,
  output logic [9:0]  b_o
);

  assign r_o = {pix_i[15:11], pix_i[15:11]};
  assign g_o = {pix_i[10:5],  pix_i[10:7]};
  assign b_o = {pix_i[4:0],   pix_i[4:0]};

endmodule

// File: rtl/vga_sram_sched.sv
// Single-port pixel SRAM scheduler: display fetch has priority on even columns,
// the filter client takes the rest; front/back banks swap at vsync fall.
module vga_sram_sched
  import vga_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clk27,
  input  logic          rst27,
  input  logic          request,
  input  logic [9:0]    current_x,
  input  logic [9:0]    current_y,
  input  logic          vga_vs,
  output logic [9:0]    r,
  output logic [9:0]    g,
  output logic [9:0]    b,
  vga_sram_sched_if.slave cli,
  input  logic          swap_req,
  output logic          swap_done,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  slot_e          slot;
  slot_e          s1Slot_q, s1Slot_d;
  logic           s1We_q, s1We_d;
  logic [AW-1:0]  sramAddr_q, sramAddr_d;
  logic [DW-1:0]  sramDqO_q, sramDqO_d;
  logic           sramDqOe_q, sramDqOe_d;
  logic           ceN_q, ceN_d, oeN_q, oeN_d, weN_q, weN_d;
  logic [DW-1:0]  pixel_q, pixel_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic           reqD1_q, reqD2_q;
  logic           dispBank_q, dispBank_d;
  logic           swapPending_q, swapPending_d;
  logic           vsPrev_q;
  logic           swapDone_q, swapDone_d;
  logic           vsFall, pendingNow;
  logic [9:0]     rExp, gExp, bExp;
  logic           unusedBits;

  assign unusedBits = current_y[9] ^ current_y[0];

  always_comb begin
    slot          = SLOT_IDLE;
    s1Slot_d      = SLOT_IDLE;
    s1We_d        = 1'b0;
    sramAddr_d    = sramAddr_q;
    sramDqO_d     = sramDqO_q;
    sramDqOe_d    = 1'b0;
    ceN_d         = 1'b1;
    oeN_d         = 1'b1;
    weN_d         = 1'b1;
    pixel_d       = pixel_q;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    dispBank_d    = dispBank_q;
    swapPending_d = swapPending_q;
    swapDone_d    = 1'b0;
    vsFall        = vsPrev_q & ~vga_vs;
    pendingNow    = swapPending_q | swap_req;

    if (request && !current_x[0]) slot = SLOT_DISP;
    else if (cli.cli_req)          slot = SLOT_CLI;

    s1Slot_d = slot;
    case (slot)
      SLOT_DISP: begin
        sramAddr_d = {dispBank_q, current_y[8:1], current_x[9:1]};
        ceN_d      = 1'b0;
        oeN_d      = 1'b0;
      end
      SLOT_CLI: begin
        // The bank is frozen here, so a later swap cannot retarget this access.
        sramAddr_d = {~dispBank_q, cli.cli_addr};
        ceN_d      = 1'b0;
        s1We_d     = cli.cli_we;
        if (cli.cli_we) begin
          sramDqO_d  = cli.cli_wdata;
          sramDqOe_d = 1'b1;
          weN_d      = 1'b0;
        end else begin
          oeN_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (s1Slot_q == SLOT_DISP) pixel_d = sram_dq_i;
    if (s1Slot_q == SLOT_CLI && !s1We_q) begin
      rvalid_d = 1'b1;
      rdata_d  = sram_dq_i;
    end

    swapPending_d = pendingNow;
    if (vsFall && pendingNow) begin
      dispBank_d    = ~dispBank_q;
      swapPending_d = 1'b0;
      swapDone_d    = 1'b1;
    end
  end

  always_ff @(posedge clk27) begin
    if (rst27) begin
      s1Slot_q      <= SLOT_IDLE;
      s1We_q        <= 1'b0;
      sramAddr_q    <= '0;
      sramDqO_q     <= '0;
      sramDqOe_q    <= 1'b0;
      ceN_q         <= 1'b1;
      oeN_q         <= 1'b1;
      weN_q         <= 1'b1;
      pixel_q       <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      reqD1_q       <= 1'b0;
      reqD2_q       <= 1'b0;
      dispBank_q    <= 1'b0;
      swapPending_q <= 1'b0;
      vsPrev_q      <= 1'b1;
      swapDone_q    <= 1'b0;
    end else begin
      s1Slot_q      <= s1Slot_d;
      s1We_q        <= s1We_d;
      sramAddr_q    <= sramAddr_d;
      sramDqO_q     <= sramDqO_d;
      sramDqOe_q    <= sramDqOe_d;
      ceN_q         <= ceN_d;
      oeN_q         <= oeN_d;
      weN_q         <= weN_d;
      pixel_q       <= pixel_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      reqD1_q       <= request;
      reqD2_q       <= reqD1_q;
      dispBank_q    <= dispBank_d;
      swapPending_q <= swapPending_d;
      vsPrev_q      <= vga_vs;
      swapDone_q    <= swapDone_d;
    end
  end

  rgb565_expand u_expand (
    .pix_i (pixel_q),
    .r_o   (rExp),
    .g_o   (gExp),
    .b_o   (bExp)
  );

  // Gate with the two-cycle-delayed request so blanking is always black.
  assign r = reqD2_q ? rExp : 10'd0;
  assign g = reqD2_q ? gExp : 10'd0;
  assign b = reqD2_q ? bExp : 10'd0;

  assign cli.cli_gnt    = (slot == SLOT_CLI);
  assign cli.cli_rvalid = rvalid_q;
  assign cli.cli_rdata  = rdata_q;
  assign swap_done      = swapDone_q;
  assign sram_addr      = sramAddr_q;
  assign sram_dq_o      = sramDqO_q;
  assign sram_dq_oe     = sramDqOe_q;
  assign sram_ce_n      = ceN_q;
  assign sram_oe_n      = oeN_q;
  assign sram_we_n      = weN_q;

endmodule
